traffic_ctrl_n: RTL

Parametrised N-way traffic-light controller, successor to the fixed four-light intersection top level. Brings lights up with a staggered red startup sequence, then runs a round-robin green/yellow/all-red cycle. The cycle honours preset jumps, preferential (priority) requests, per-light force-red and a global blinking-yellow attention mode. It drives all lamp outputs of one intersection directly from registers.

---
 rtl/traffic_ctrl_n_pkg.sv | 25 ++
 rtl/traffic_ctrl_n_if.sv | 27 ++
 rtl/traffic_rr_arbiter.sv | 74 +++++++
 rtl/traffic_ctrl_n.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_ctrl_n_pkg.sv
// Shared types and constants for the N-way traffic-light controller.
// Optional green extension is enabled by TRAFFIC_GREEN_EXTEND_EN.
package traffic_pkg;

   typedef enum logic [2:0] {
      OFF,
      STARTUP,
      GREEN,
      YELLOW,
      ALLRED,
      ATTN
   } state_e;

   localparam logic [2:0] LAMP_OFF    = 3'b000;
   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   localparam int STARTUP_HOLD = 2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/traffic_ctrl_n_if.sv
// Request inputs and lamp outputs of one intersection.
// master drives requests, slave is the controller.
interface traffic_ctrl_n_if
   import traffic_pkg::*;
#(
   parameter int N_LIGHTS = 4
);
   logic                     attention;
   logic                     preset;
   logic [N_LIGHTS-1:0]      preset_adds;
   logic [N_LIGHTS-1:0]      force_reds;
   logic [N_LIGHTS-1:0]      preferentials;
   logic [N_LIGHTS-1:0][0:2] ltfs;
   logic [N_LIGHTS-1:0]      lgreen;

   modport master (
      output attention, preset, preset_adds,
      output force_reds, preferentials,
      input  ltfs, lgreen
   );

   modport slave (
      input  attention, preset, preset_adds,
      input  force_reds, preferentials,
      output ltfs, lgreen
   );
endinterface

// File: rtl/traffic_rr_arbiter.sv
// Next-green selection: preset, then lowest preferential,
// then round-robin after the last green; forced-red lights never win.
module traffic_rr_arbiter
   import traffic_pkg::*;
#(
   parameter int N_LIGHTS = 4
) (
   input  logic [N_LIGHTS-1:0]         force_reds_i,
   input  logic                        preset_vld_i,
   input  logic [N_LIGHTS-1:0]         preset_oh_i,
   input  logic [N_LIGHTS-1:0]         prefs_i,
   input  logic [$clog2(N_LIGHTS)-1:0] last_i,
   output logic                        gnt_vld_o,
   output logic [$clog2(N_LIGHTS)-1:0] gnt_idx_o,
   output logic                        use_preset_o
);
   localparam int IW = $clog2(N_LIGHTS);

   logic          pre_any, pf_any, rr_any;
   logic [IW-1:0] pre_idx, pf_idx, rr_idx;
   logic          p_ok, f_ok, r_ok;

   always_comb begin
      pre_any = 1'b0;
      pre_idx = '0;
      pf_any  = 1'b0;
      pf_idx  = '0;
      rr_any  = 1'b0;
      rr_idx  = '0;
      // descending scans leave the lowest qualifying index
      for (int i = N_LIGHTS-1; i >= 0; i--) begin
         if (preset_oh_i[i]) begin
            pre_any = 1'b1;
            pre_idx = IW'(i);
         end
         if (prefs_i[i] && !force_reds_i[i]) begin
            pf_any = 1'b1;
            pf_idx = IW'(i);
         end
      end
      for (int k = N_LIGHTS; k >= 1; k--) begin
         if (!force_reds_i[(int'(last_i) + k) % N_LIGHTS]) begin
            rr_any = 1'b1;
            rr_idx = IW'((int'(last_i) + k) % N_LIGHTS);
         end
      end
   end

   assign p_ok = preset_vld_i && pre_any && !force_reds_i[pre_idx];
   assign f_ok = pf_any && !p_ok;
   assign r_ok = rr_any && !p_ok && !pf_any;

   always_comb begin
      gnt_vld_o    = 1'b0;
      gnt_idx_o    = '0;
      use_preset_o = 1'b0;
      unique case (1'b1)
         p_ok: begin
            gnt_vld_o    = 1'b1;
            gnt_idx_o    = pre_idx;
            use_preset_o = 1'b1;
         end
         f_ok: begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = pf_idx;
         end
         r_ok: begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = rr_idx;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/traffic_ctrl_n.sv
// N-way traffic-light controller with staggered startup and attention blink.
// TRAFFIC_GREEN_EXTEND_EN: a preferential for the green light extends it once.
module traffic_ctrl_n
   import traffic_pkg::*;
#(
   parameter int N_LIGHTS       = 4,
   parameter int STARTUP_CYCLES = 7,
   parameter int GREEN_CYCLES   = 8,
   parameter int YELLOW_CYCLES  = 2,
   parameter int ALLRED_CYCLES  = 1,
   parameter int BLINK_CYCLES   = 4
) (
   input logic            clk,
   input logic            rst,
   traffic_ctrl_n_if.slave bus
);
   localparam int IW   = $clog2(N_LIGHTS);
   localparam int MAXC = max2(max2(max2(STARTUP_CYCLES, GREEN_CYCLES),
                                   max2(YELLOW_CYCLES, ALLRED_CYCLES)),
                              max2(BLINK_CYCLES, STARTUP_HOLD));
   localparam int CW   = $clog2(MAXC) + 1;

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [IW-1:0]            last_q, last_d;
   logic [N_LIGHTS-1:0]      pref_q, pref_d;
   logic                     pre_vld_q, pre_vld_d;
   logic [N_LIGHTS-1:0]      pre_oh_q, pre_oh_d;
   logic                     blink_q, blink_d;
   logic [N_LIGHTS-1:0][0:2] ltfs_q, ltfs_d;
   logic [N_LIGHTS-1:0]      lgreen_q, lgreen_d;

   logic                accept, cnt_one;
   logic [N_LIGHTS-1:0] pref_in, pref_eff, pre_oh_eff;
   logic                pre_vld_eff;
   logic                gnt_vld, use_preset;
   logic [IW-1:0]       gnt_idx;

`ifdef TRAFFIC_GREEN_EXTEND_EN
   logic [1:0]          ext_q, ext_d;
   logic [N_LIGHTS-1:0] gmask;
   assign gmask   = (state_q == GREEN) ? (N_LIGHTS'(1) << idx_q) : '0;
   assign pref_in = bus.preferentials & ~gmask;
`else
   assign pref_in = bus.preferentials;
`endif

   assign accept      = (state_q != OFF) && (state_q != STARTUP);
   assign cnt_one     = (cnt_q == CW'(1));
   assign pref_eff    = accept ? (pref_q | pref_in) : pref_q;
   assign pre_vld_eff = (accept && bus.preset) ? |bus.preset_adds : pre_vld_q;
   assign pre_oh_eff  = (accept && bus.preset) ? bus.preset_adds : pre_oh_q;

   traffic_rr_arbiter #(
      .N_LIGHTS (N_LIGHTS)
   ) u_arb (
      .force_reds_i (bus.force_reds),
      .preset_vld_i (pre_vld_eff),
      .preset_oh_i  (pre_oh_eff),
      .prefs_i      (pref_eff),
      .last_i       (last_q),
      .gnt_vld_o    (gnt_vld),
      .gnt_idx_o    (gnt_idx),
      .use_preset_o (use_preset)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      last_d    = last_q;
      pref_d    = pref_eff;
      pre_vld_d = pre_vld_eff;
      pre_oh_d  = pre_oh_eff;
      blink_d   = blink_q;
`ifdef TRAFFIC_GREEN_EXTEND_EN
      ext_d     = ext_q;
`endif
      if (accept && bus.attention && state_q != ATTN) begin
         state_d = ATTN;
         cnt_d   = CW'(BLINK_CYCLES);
         blink_d = 1'b1;
      end else begin
         unique case (state_q)
            OFF: begin
               if (cnt_one) begin
                  state_d = STARTUP;
                  idx_d   = '0;
                  cnt_d   = CW'(STARTUP_CYCLES);
               end else cnt_d = cnt_q - CW'(1);
            end
            STARTUP: begin
               if (!cnt_one) cnt_d = cnt_q - CW'(1);
               else if (idx_q == IW'(N_LIGHTS-1)) begin
                  state_d = ALLRED;
                  cnt_d   = CW'(ALLRED_CYCLES);
                  last_d  = IW'(N_LIGHTS-1);
               end else begin
                  idx_d = idx_q + IW'(1);
                  cnt_d = (idx_d == IW'(N_LIGHTS-1)) ?
                          CW'(1) : CW'(STARTUP_CYCLES);
               end
            end
            ALLRED: begin
               if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
               else if (gnt_vld) begin
                  state_d         = GREEN;
                  cnt_d           = CW'(GREEN_CYCLES);
                  idx_d           = gnt_idx;
                  last_d          = gnt_idx;
                  pref_d[gnt_idx] = 1'b0;
                  if (use_preset) pre_vld_d = 1'b0;
`ifdef TRAFFIC_GREEN_EXTEND_EN
                  ext_d = 2'b00;
`endif
               end
            end
            GREEN: begin
`ifdef TRAFFIC_GREEN_EXTEND_EN
               if (bus.preferentials[idx_q]) ext_d[0] = 1'b1;
`endif
               if (bus.force_reds[idx_q]) begin
                  state_d = YELLOW;
                  cnt_d   = CW'(YELLOW_CYCLES);
               end else if (cnt_one) begin
`ifdef TRAFFIC_GREEN_EXTEND_EN
                  if ((ext_q[0] || bus.preferentials[idx_q]) && !ext_q[1]) begin
                     cnt_d    = CW'(GREEN_CYCLES);
                     ext_d[1] = 1'b1;
                  end else begin
                     state_d = YELLOW;
                     cnt_d   = CW'(YELLOW_CYCLES);
                  end
`else
                  state_d = YELLOW;
                  cnt_d   = CW'(YELLOW_CYCLES);
`endif
               end else cnt_d = cnt_q - CW'(1);
            end
            YELLOW: begin
               if (cnt_one) begin
                  state_d = ALLRED;
                  cnt_d   = CW'(ALLRED_CYCLES);
               end else cnt_d = cnt_q - CW'(1);
            end
            ATTN: begin
               if (!bus.attention) begin
                  state_d = ALLRED;
                  cnt_d   = CW'(ALLRED_CYCLES);
               end else if (cnt_one) begin
                  blink_d = !blink_q;
                  cnt_d   = CW'(BLINK_CYCLES);
               end else cnt_d = cnt_q - CW'(1);
            end
            default: state_d = OFF;
         endcase
      end
   end

   // lamps decoded from next state so outputs come straight from flops
   always_comb begin
      ltfs_d   = '0;
      lgreen_d = '0;
      unique case (state_d)
         STARTUP: begin
            for (int i = 0; i < N_LIGHTS; i++)
               if (i <= int'(idx_d)) ltfs_d[i] = LAMP_RED;
         end
         ALLRED: begin
            for (int i = 0; i < N_LIGHTS; i++) ltfs_d[i] = LAMP_RED;
         end
         GREEN: begin
            for (int i = 0; i < N_LIGHTS; i++) ltfs_d[i] = LAMP_RED;
            ltfs_d[idx_d]   = LAMP_GREEN;
            lgreen_d[idx_d] = 1'b1;
         end
         YELLOW: begin
            for (int i = 0; i < N_LIGHTS; i++) ltfs_d[i] = LAMP_RED;
            ltfs_d[idx_d] = LAMP_YELLOW;
         end
         ATTN: begin
            for (int i = 0; i < N_LIGHTS; i++)
               ltfs_d[i] = blink_d ? LAMP_YELLOW : LAMP_OFF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= OFF;
         cnt_q     <= CW'(STARTUP_HOLD);
         idx_q     <= '0;
         last_q    <= '0;
         pref_q    <= '0;
         pre_vld_q <= 1'b0;
         pre_oh_q  <= '0;
         blink_q   <= 1'b0;
         ltfs_q    <= '0;
         lgreen_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         pref_q    <= pref_d;
         pre_vld_q <= pre_vld_d;
         pre_oh_q  <= pre_oh_d;
         blink_q   <= blink_d;
         ltfs_q    <= ltfs_d;
         lgreen_q  <= lgreen_d;
      end
   end

`ifdef TRAFFIC_GREEN_EXTEND_EN
   always_ff @(posedge clk) begin
      if (rst) ext_q <= 2'b00;
      else     ext_q <= ext_d;
   end
`endif

   assign bus.ltfs   = ltfs_q;
   assign bus.lgreen = lgreen_q;
endmodule
